// File: rtl/wts_noise_generator_mc.sv
// Multi-channel LFSR noise generator for the wave-table sound core, advanced on the `active` pulse.
// Optional short (127-step) LFSR mode is enabled by defining WTS_NOISE_SHORT_MODE_EN.
module wts_noise_generator_mc #(
  parameter int unsigned FR_W = 5,
  parameter int unsigned NCH  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            active,
  input  logic [NCH-1:0]  enable,
  input  logic [FR_W-1:0] reg_fr,
  input  logic            reg_fr_wr,
  input  logic            reg_mode,
  input  logic            seed_req,
  output logic [NCH-1:0]  noise,
  output logic            step
);

  localparam int unsigned LFSR_W = 18;
  localparam logic [LFSR_W-1:0] LFSR_SEED = '1;

  logic [FR_W-1:0]   ff_cnt;
  logic [LFSR_W-1:0] ff_noise;
  logic              ff_step;

  logic cnt_end;
  logic do_shift;
  logic fb_long;
  logic fb;
  logic lfsr_out;

  assign cnt_end  = (ff_cnt == '0);
  assign do_shift = active & cnt_end;

  // All-zero lock guard forces a 1 into the register
  assign fb_long = (ff_noise == '0) ? 1'b1 : (ff_noise[17] ^ ff_noise[14]);

`ifdef WTS_NOISE_SHORT_MODE_EN
  logic fb_short;

  assign fb_short = (ff_noise[6:0] == '0) ? 1'b1 : (ff_noise[6] ^ ff_noise[5]);
  assign fb       = reg_mode ? fb_short : fb_long;
  assign lfsr_out = reg_mode ? ff_noise[6] : ff_noise[17];
`else
  logic unused_reg_mode;

  assign unused_reg_mode = reg_mode;
  assign fb              = fb_long;
  assign lfsr_out        = ff_noise[17];
`endif

  // Period divider; a register write restarts it so the next pulse shifts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_cnt <= '0;
    end else if (reg_fr_wr) begin
      ff_cnt <= '0;
    end else if (active) begin
      ff_cnt <= (cnt_end ? reg_fr : ff_cnt) - FR_W'(1);
    end
  end

  // LFSR state; software reseed overrides a coincident shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_noise <= LFSR_SEED;
    end else if (seed_req) begin
      ff_noise <= LFSR_SEED;
    end else if (do_shift) begin
      ff_noise <= {ff_noise[LFSR_W-2:0], fb};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_step <= 1'b0;
    end else begin
      ff_step <= do_shift & ~seed_req;
    end
  end

  assign step  = ff_step;
  assign noise = ~enable | {NCH{lfsr_out}};

endmodule

// File: doc/wts_noise_generator_mc.md
# wts_noise_generator_mc

Parametrised multi-channel noise generator for the wave-table sound core. It is the successor of the single-channel 5-bit noise generator and adds:
- a configurable frequency-divider width;
- per-channel enable gating;
- an optional short (periodic, 127-step) LFSR mode;
- a register-write restart;
- a software reseed.

It sits beside the channel mixers, is clocked by the system clock and advances only on the 3.579 MHz `active` timing pulse.

## Interface
- `FR_W`, default 5: width of the frequency divider register, 2..16.
- `NCH`, default 5: number of gated noise outputs, 1..8.
- `clk` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: reset, asynchronous and active-high.
- `active` input 1: 3.579 MHz timing pulse, one `clk` wide.
- `enable` input `NCH`: per-channel noise enable; 0 forces that output to 1.
- `reg_fr` input `FR_W`: noise period in `active` pulses; 0 means 2^`FR_W`.
- `reg_fr_wr` input 1: one-cycle strobe, asserted when `reg_fr` is written.
- `reg_mode` input 1: 0 selects long LFSR, 1 selects short LFSR (only with the macro).
- `seed_req` input 1: one-cycle strobe that reloads the LFSR to all ones.
- `noise` output `NCH`: `noise[i] = ~enable[i] | lfsr_out`; combinational from registers and `enable`.
- `step` output 1: registered; a one-cycle pulse in the cycle after each LFSR shift.

## Operation
- State: `ff_cnt[FR_W-1:0]`, `ff_noise[17:0]`, `ff_step`.
- Divider, evaluated only when `active` = 1:
  - `cnt_end = (ff_cnt == 0)`;
  - next `ff_cnt = (cnt_end ? reg_fr : ff_cnt) - 1`, modulo 2^`FR_W`.
  - Result: for `reg_fr` = N ≥ 1, one shift every N `active` pulses; for N = 0, one shift every 2^`FR_W` pulses.
- Shift: when `active` & `cnt_end`, `ff_noise <= {ff_noise[16:0], fb}`.
- Long mode (`reg_mode` = 0):
  - `fb = ff_noise[17] ^ ff_noise[14]`;
  - `lfsr_out = ff_noise[17]`;
  - lock guard: if `ff_noise == 0`, `fb = 1`.
- Short mode (`reg_mode` = 1):
  - `fb = ff_noise[6] ^ ff_noise[5]`;
  - `lfsr_out = ff_noise[6]`;
  - period 127 shifts;
  - lock guard: if `ff_noise[6:0] == 0`, `fb = 1`;
  - bits [17:7] keep shifting but are don't-care in this mode.
- Mode change does not reseed. The new taps apply at the next shift, and `lfsr_out` selection changes immediately.
- `reg_fr_wr` = 1 forces `ff_cnt <= 0`, so the first `active` pulse afterwards shifts and reloads from the new `reg_fr`. A new period therefore takes effect without waiting for the old count.
- `seed_req` = 1 forces `ff_noise <= 18'h3FFFF`.
- `ff_step <= active & cnt_end & ~seed_req`.

## Timing
- Reset values:
  - `ff_cnt` = 0, `ff_noise` = 18'h3FFFF, `ff_step` = 0;
  - hence `noise` = all ones and `step` = 0.
- With `reg_fr` held, the first `active` after reset shifts, because `ff_cnt` = 0.
- `noise` changes in the cycle after the shifting `active` edge; `step` is high in that same cycle.
- Simultaneous events:
  - `reg_fr_wr` with `active`: the write wins; `ff_cnt <= 0`, but a shift still occurs if `cnt_end` was already 1.
  - `seed_req` with a shift: the seed wins; `ff_noise` = all ones, no `step`.
  - `seed_req` with `reg_fr_wr`: both take effect.
- `active` = 0: all state holds, and strobes still act.
- Reset asserted mid-operation: all state is cleared asynchronously, with no glitch on `noise` beyond the forced-ones level.
- `reg_fr` is sampled only at `cnt_end`. A change without `reg_fr_wr` takes effect at the next reload.

## Configuration
- `WTS_NOISE_SHORT_MODE_EN` defined: `reg_mode` behaves as described above.
- Undefined:
  - `reg_mode` is ignored and long mode is permanent;
  - the short-tap feedback and output mux are not synthesised;
  - the port remains present and is unconnected internally.

## Test plan
- Reset, `reg_fr` = 1, `enable` = all ones, `active` every 4 clk:
  - `noise` stays all ones for the first 18 shifts;
  - the first 0 appears after shift 18;
  - `step` pulses once per `active`.
- Macro defined, `reg_mode` = 1 from reset, `reg_fr` = 1:
  - `noise` first 0 after shift 7;
  - the sequence repeats exactly every 127 shifts.
- `reg_fr` = 3 → 3 `active` pulses between `step` pulses.
- `reg_fr` = 0, `FR_W` = 5 → 32 pulses between `step` pulses.
- With `reg_fr` = 20 and mid-count, write `reg_fr` = 2 with `reg_fr_wr` → shift on the next `active`, then every 2.
- Run 40 shifts, pulse `seed_req` with a shifting `active` → `ff_noise` = 3FFFF, no `step`; then repeat scenario 1's 18-shift ones run.
- `enable` = 5'b10101 at any point → `noise[1]` and `noise[3]` read 1 constantly; the others equal `lfsr_out`.
- Assert `reset` mid-sequence → `noise` = all ones and `step` = 0 immediately, without waiting for a `clk` edge.
